btb_update: RTL and testbench

- Branch-resolution update stage that sits directly upstream of the BTB storage file's update and write ports.
- Accepts one resolved branch (PC, taken, target) from execute via a valid/ready handshake.
- Reads the indexed 128-bit set through the file's update read port, applies 2-way hit/allocate/counter/LRU rules, and writes the modified set back.
- Sequential read-modify-write; one update in flight; throughput of one update per 3 cycles.

---
 rtl/btb_update.sv | 163 ++++++++++++++++
 tb/tb_btb_update.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update.sv
// BTB update stage: read-modify-write of one 2-way set per resolved branch.
// Hit updates counter/target, a taken miss allocates a way, and the LRU bit lives in set[0].
module btb_update #(
    parameter int PC_W    = 32,
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 27,
    parameter int SET_W   = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [PC_W-1:0]    upd_pc,
    input  logic               upd_taken,
    input  logic [PC_W-1:0]    upd_target,
    output logic [INDEX_W-1:0] update_index,
    input  logic [SET_W-1:0]   update_set,
    output logic [INDEX_W-1:0] write_index,
    output logic [SET_W-1:0]   write_set,
    output logic               write_en,
    output logic               upd_hit,
    output logic               upd_alloc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [PC_W-1:2]     r_pc;
    logic                r_taken;
    logic [PC_W-1:0]     r_target;
    logic [SET_W-1:0]    r_set;
    logic                w_accept;
    logic                w_hit0;
    logic                w_hit1;
    logic                w_victim1;
    logic                w_lru;
    logic [63:0]         w_new0;
    logic [63:0]         w_new1;
    logic                w_unused;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        if (taken) begin
            res = (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
        end else begin
            res = (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
        end
        return res;
    endfunction

    function automatic logic [63:0] hit_way(input logic [63:0] way, input logic taken,
                                            input logic [31:0] target);
        logic [63:0] res;
        res        = way;
        res[62:61] = ctr_next(way[62:61], taken);
        if (taken) begin
            res[33:2] = target;
        end else begin
            res[33:2] = way[33:2];
        end
        res[1:0] = 2'b00;
        return res;
    endfunction

    function automatic logic [63:0] alloc_way(input logic [TAG_W-1:0] tag, input logic [31:0] target);
        return {1'b1, 2'b10, tag, target, 2'b00};
    endfunction

    assign w_accept     = upd_valid && upd_ready;
    assign upd_ready    = rst && (r_state == S_IDLE);
    assign update_index = r_pc[INDEX_W+1:2];
    assign write_index  = r_pc[INDEX_W+1:2];
    assign w_hit0       = r_set[63]  && (r_set[60:34]  == r_pc[PC_W-1:5]);
    assign w_hit1       = r_set[127] && (r_set[124:98] == r_pc[PC_W-1:5]);
    // Way0 is filled first; once both are valid the LRU bit picks the victim.
    assign w_victim1    = r_set[63] && (!r_set[127] || r_set[0]);
    assign w_unused     = ^{upd_pc[1:0], r_set[65:64], r_set[1]};

    // State, request and set-snapshot registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_taken  <= 1'b0;
            r_target <= '0;
            r_set    <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_pc     <= upd_pc[PC_W-1:2];
                r_taken  <= upd_taken;
                r_target <= upd_target;
            end
            if (r_state == S_READ) begin
                r_set <= update_set;
            end
        end
    end

    // Next state and write-back decode; ways keep their contents unless hit or allocated.
    always_comb begin
        w_next_state = r_state;
        write_en     = 1'b0;
        upd_hit      = 1'b0;
        upd_alloc    = 1'b0;
        write_set    = '0;
        w_new0       = {r_set[63:2], 2'b00};
        w_new1       = {r_set[127:66], 2'b00};
        w_lru        = r_set[0];
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_READ;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_READ: begin
                w_next_state = S_WRITE;
            end
            S_WRITE: begin
                w_next_state = S_IDLE;
                if (w_hit0) begin
                    w_new0   = hit_way(w_new0, r_taken, r_target);
                    w_lru    = 1'b1;
                    write_en = 1'b1;
                    upd_hit  = 1'b1;
                end else if (w_hit1) begin
                    w_new1   = hit_way(w_new1, r_taken, r_target);
                    w_lru    = 1'b0;
                    write_en = 1'b1;
                    upd_hit  = 1'b1;
                end else if (r_taken) begin
                    if (w_victim1) begin
                        w_new1 = alloc_way(r_pc[PC_W-1:5], r_target);
                        w_lru  = 1'b0;
                    end else begin
                        w_new0 = alloc_way(r_pc[PC_W-1:5], r_target);
                        w_lru  = 1'b1;
                    end
                    write_en  = 1'b1;
                    upd_alloc = 1'b1;
                end else begin
                    write_en = 1'b0;
                end
                if (write_en) begin
                    write_set = {w_new1, w_new0[63:1], w_lru};
                end else begin
                    write_set = '0;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_btb_update.sv
// Randomized bench for btb_update: a field-level BTB model predicts every update and the
// per-cycle handshake/write behaviour; directed literal set values pin the model.
module tb_btb_update;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         upd_valid = 1'b0;
    logic         upd_taken = 1'b0;
    logic [31:0]  upd_pc = 32'h0;
    logic [31:0]  upd_target = 32'h0;
    logic         upd_ready;
    logic [2:0]   update_index;
    logic [127:0] update_set;
    logic [2:0]   write_index;
    logic [127:0] write_set;
    logic         write_en;
    logic         upd_hit;
    logic         upd_alloc;

    logic [127:0] file_mem [8] = '{default: 128'h0};
    logic [127:0] m_mem    [8] = '{default: 128'h0};
    int           m_phase = 0;
    logic [2:0]   m_idx;
    logic [127:0] m_set;
    logic         m_we, m_hit, m_alloc;
    int           errors = 0;
    int           checks = 0;

    btb_update dut (
        .clk(clk), .rst(rst), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .update_index(update_index), .update_set(update_set),
        .write_index(write_index), .write_set(write_set), .write_en(write_en),
        .upd_hit(upd_hit), .upd_alloc(upd_alloc)
    );

    always #5 clk = ~clk;

    // Storage file seen by the DUT: combinational read, write at the clock edge.
    assign update_set = file_mem[update_index];
    always @(posedge clk) begin
        if (write_en) file_mem[write_index] <= write_set;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference BTB rules applied to decoded way fields.
    function automatic logic [127:0] model_apply(input logic [127:0] s, input logic [31:0] pc,
        input logic tk, input logic [31:0] tgt, output logic we, output logic hit, output logic alloc);
        logic        vld [2];
        int          ctr [2];
        logic [26:0] tg  [2];
        logic [31:0] ta  [2];
        int          lru, hw, vic;
        logic [127:0] r;
        for (int w = 0; w < 2; w++) begin
            vld[w] = s[64*w+63];
            ctr[w] = int'(s[64*w+61 +: 2]);
            tg[w]  = s[64*w+34 +: 27];
            ta[w]  = s[64*w+2 +: 32];
        end
        lru = int'(s[0]);
        hw  = -1;
        for (int w = 1; w >= 0; w--) begin
            if (vld[w] && tg[w] == pc[31:5]) hw = w;
        end
        we = 1'b0; hit = 1'b0; alloc = 1'b0;
        if (hw >= 0) begin
            hit = 1'b1; we = 1'b1;
            if (tk) begin
                ctr[hw] = (ctr[hw] < 3) ? ctr[hw] + 1 : 3;
                ta[hw]  = tgt;
            end else begin
                ctr[hw] = (ctr[hw] > 0) ? ctr[hw] - 1 : 0;
            end
            lru = 1 - hw;
        end else if (tk) begin
            vic = !vld[0] ? 0 : (!vld[1] ? 1 : lru);
            vld[vic] = 1'b1; ctr[vic] = 2; tg[vic] = pc[31:5]; ta[vic] = tgt;
            lru = 1 - vic; we = 1'b1; alloc = 1'b1;
        end
        r = '0;
        for (int w = 0; w < 2; w++) begin
            r[64*w+63]       = vld[w];
            r[64*w+61 +: 2]  = 2'(ctr[w]);
            r[64*w+34 +: 27] = tg[w];
            r[64*w+2 +: 32]  = ta[w];
        end
        r[0] = lru[0];
        return r;
    endfunction

    // Per-cycle compare against the model: idle -> read -> write, reset discards the request.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_ready", upd_ready, 1'b0);
                check("rst_write_en", write_en, 1'b0);
                check("rst_write_set", write_set, 128'h0);
                m_phase = 0;
            end else if (m_phase == 0) begin
                check("idle_ready", upd_ready, 1'b1);
                check("idle_write_en", write_en, 1'b0);
                if (upd_valid) begin
                    m_idx   = upd_pc[4:2];
                    m_set   = model_apply(m_mem[upd_pc[4:2]], upd_pc, upd_taken, upd_target,
                                          m_we, m_hit, m_alloc);
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                check("read_ready", upd_ready, 1'b0);
                check("read_index", update_index, m_idx);
                check("read_write_en", write_en, 1'b0);
                m_phase = 2;
            end else begin
                check("wr_ready", upd_ready, 1'b0);
                check("wr_write_en", write_en, m_we);
                check("wr_hit", upd_hit, m_hit);
                check("wr_alloc", upd_alloc, m_alloc);
                if (m_we) begin
                    check("wr_index", write_index, m_idx);
                    check("wr_set", write_set, m_set);
                    m_mem[m_idx] = m_set;
                end
                m_phase = 0;
            end
        end
    end

    // Present a request, wait for acceptance, optionally keep valid high, return after commit.
    task automatic send(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic hold);
        int n = 0;
        upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
        do begin
            @(negedge clk);
            n++;
        end while (!upd_ready && n < 20);
        check("accept", upd_ready, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) upd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    // Accept a request, then pull reset after nwait further edges (0 = read, 1 = write cycle).
    task automatic abort_req(input logic [31:0] pc, input logic [31:0] tgt, input int nwait);
        int n = 0;
        upd_valid = 1'b1; upd_pc = pc; upd_taken = 1'b1; upd_target = tgt;
        do begin
            @(negedge clk);
            n++;
        end while (!upd_ready && n < 20);
        check("abort_accept", upd_ready, 1'b1);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        repeat (nwait) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] saved;
        logic [26:0]  tag;
        #2;
        rst = 1'b0;
        upd_valid = 1'b1; upd_pc = 32'h0000_1008; upd_taken = 1'b1; upd_target = 32'h0000_2000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        upd_valid = 1'b0;
        @(negedge clk);
        check("ready_after_reset", upd_ready, 1'b1);
        @(posedge clk);
        #1;

        send(32'h0000_1008, 1'b1, 32'h0000_2000, 1'b0);
        check("cold_alloc_file", file_mem[2], {64'h0, 64'hC000_0200_0000_8001});
        check("cold_alloc_model", m_mem[2], {64'h0, 64'hC000_0200_0000_8001});
        send(32'h0000_1008, 1'b1, 32'h0000_2000, 1'b0);
        check("hit_sat1", file_mem[2], {64'h0, 64'hE000_0200_0000_8001});
        send(32'h0000_1008, 1'b1, 32'h0000_2000, 1'b0);
        check("hit_sat2", file_mem[2], {64'h0, 64'hE000_0200_0000_8001});
        send(32'h0000_1008, 1'b0, 32'h0000_3000, 1'b1);
        check("hit_nt_held", file_mem[2], {64'h0, 64'hC000_0200_0000_8001});
        check("hit_nt_model", m_mem[2], {64'h0, 64'hC000_0200_0000_8001});
        send(32'h0000_1028, 1'b1, 32'h0000_4000, 1'b0);
        check("alloc_way1", file_mem[2], {64'hC000_0204_0001_0000, 64'hC000_0200_0000_8000});
        send(32'h0000_1048, 1'b1, 32'h0000_5000, 1'b0);
        check("evict_way0", file_mem[2], {64'hC000_0204_0001_0000, 64'hC000_0208_0001_4001});
        check("evict_model", m_mem[2], {64'hC000_0204_0001_0000, 64'hC000_0208_0001_4001});
        send(32'h0000_100C, 1'b0, 32'h0000_6000, 1'b0);
        check("miss_nt_file", file_mem[3], 128'h0);

        saved = file_mem[2];
        abort_req(32'h0000_1048, 32'h0000_7000, 0);
        check("abort_read_file", file_mem[2], saved);
        abort_req(32'h0000_1048, 32'h0000_7000, 1);
        check("abort_write_file", file_mem[2], saved);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 4) tag = 27'($urandom);
            else tag = 27'(32'h80 + $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send({tag, 3'($urandom_range(0, 7)), 2'b00}, 1'($urandom_range(0, 1)),
                 $urandom, 1'($urandom_range(0, 1)));
        end

        for (int k = 0; k < 8; k++) begin
            check("final_file", file_mem[k], m_mem[k]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
